imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 101 ++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side (consumes bytes, drives writes); slave = source/memory side.
interface imem_loader_if #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32
) ();
    logic [7:0]               in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    modport master (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to instruction memory.
// 4th byte at edge t -> wr_en in cycle t+1; in_ready is low outside RECV and bytes are held by the source.
module imem_loader #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-2:0] num_words,
    imem_loader_if.master            bus,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-2:0] word_count
);
    localparam int CW = ADDRESS_WIDTH - 1;
    // Memory holds 2**(ADDRESS_WIDTH-2) words; longer requests are clipped to that.
    localparam logic [CW-1:0] MAX_WORDS = CW'(1) << (ADDRESS_WIDTH - 2);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CW-1:0]            n_words;
    logic [CW-1:0]            n_sat;
    logic [1:0]               byte_idx;
    logic [23:0]              word_buf;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0]    wr_data_q;
    logic                     accept_start;

    assign n_sat        = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (n_sat != '0) ? S_RECV : S_DONE;
                end
            end
            S_RECV: begin
                if (bus.in_valid && (byte_idx == 2'd3)) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = ((word_count + ONE) == n_words) ? S_DONE : S_RECV;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The completed word and its address are captured with the last byte so they
    // stay on the write port after the pulse until the next word lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_words    <= '0;
            word_count <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else if (accept_start) begin
            n_words    <= n_sat;
            word_count <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
        end else if ((state == S_RECV) && bus.in_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    word_buf[7:0]   <= bus.in_data;
                2'd1:    word_buf[15:8]  <= bus.in_data;
                2'd2:    word_buf[23:16] <= bus.in_data;
                default: begin
                    wr_data_q <= {bus.in_data, word_buf};
                    wr_addr_q <= {word_count[ADDRESS_WIDTH-3:0], 2'b00};
                end
            endcase
        end else if (state == S_WRITE) begin
            word_count <= word_count + ONE;
        end
    end

    assign bus.in_ready = (state == S_RECV);
    assign bus.wr_en    = (state == S_WRITE);
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = (state == S_RECV) || (state == S_WRITE);
    assign done         = (state == S_DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: vector table of load lengths plus hand sequences, writes checked by a scoreboard.
module tb_imem_loader;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-2:0] num_words;
    logic          busy;
    logic          done;
    logic [AW-2:0] word_count;

    imem_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    imem_loader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .num_words  (num_words),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [AW-2:0] num;
        bit            gaps;
        int            exp_words;
    } vec_t;

    wr_t           exp_q[$];
    vec_t          vecs[6];
    int            checks      = 0;
    int            failures    = 0;
    int            writes_seen = 0;
    int            cyc         = 0;
    int            last_wr_cyc = 0;
    int            prev_wr_cyc = 0;
    logic [AW-1:0] last_addr   = '0;
    bit            abort       = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        wr_t e;
        if (bus.wr_en) begin
            writes_seen++;
            prev_wr_cyc = last_wr_cyc;
            last_wr_cyc = cyc;
            last_addr   = bus.wr_addr;
            chk("in_ready_during_write", 64'(bus.in_ready), 64'(0));
            if (exp_q.size() == 0) begin
                chk("pending_writes", 64'(exp_q.size()), 64'(1));
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.wr_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   64'(bus.in_ready), 64'(0));
        chk({tag, "_wr_en"},      64'(bus.wr_en),    64'(0));
        chk({tag, "_busy"},       64'(busy),         64'(0));
        chk({tag, "_done"},       64'(done),         64'(0));
        chk({tag, "_word_count"}, 64'(word_count),   64'(0));
        chk({tag, "_wr_addr"},    64'(bus.wr_addr),  64'(0));
        chk({tag, "_wr_data"},    64'(bus.wr_data),  64'(0));
    endtask

    task automatic do_start(input logic [AW-2:0] n);
        start     = 1'b1;
        num_words = n;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        if (abort) return;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && g < 50) begin
            tick();
            g++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 64'(bus.in_ready), 64'(1));
            abort        = 1'b1;
            bus.in_valid = 1'b0;
            return;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx, input bit gaps);
        for (int k = 0; k < 4; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (k == 3) exp_q.push_back('{addr: AW'(idx * 4), data: w});
            send_byte(w[8*k +: 8]);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int g = 0;
        while (!done && g < budget) begin
            tick();
            g++;
        end
        chk(name, 64'(done), 64'(1));
    endtask

    logic [7:0] b35[8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    logic [7:0] b37[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    bit         p37[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        int          base;
        int          idx;
        logic [31:0] w1;

        vecs[0] = '{num: 11'd1,    gaps: 1'b1, exp_words: 1};
        vecs[1] = '{num: 11'd3,    gaps: 1'b0, exp_words: 3};
        vecs[2] = '{num: 11'd5,    gaps: 1'b1, exp_words: 5};
        vecs[3] = '{num: 11'd0,    gaps: 1'b0, exp_words: 0};
        vecs[4] = '{num: 11'd2047, gaps: 1'b0, exp_words: 1024};
        vecs[5] = '{num: 11'd1025, gaps: 1'b1, exp_words: 1024};

        reset        = 1'b0;
        start        = 1'b0;
        num_words    = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        #1 reset = 1'b1;
        #2 check_reset_outputs("rst");
        repeat (2) tick();
        reset = 1'b0;

        // Two-word load with fixed program bytes, in_valid held high
        base = writes_seen;
        do_start(11'd2);
        chk("start_busy", 64'(busy), 64'(1));
        exp_q.push_back('{addr: 12'h000, data: 32'h0050_0013});
        exp_q.push_back('{addr: 12'h004, data: 32'h0010_0093});
        for (int i = 0; i < 8; i++) send_byte(b35[i]);
        wait_done(20, "two_word_done");
        chk("two_word_count", 64'(word_count), 64'(2));
        chk("two_word_writes", 64'(writes_seen - base), 64'(2));
        chk("two_word_spacing", 64'(last_wr_cyc - prev_wr_cyc), 64'(5));
        chk("two_word_sb_empty", 64'(exp_q.size()), 64'(0));

        // Zero-length load
        base = writes_seen;
        do_start(11'd0);
        chk("zero_done", 64'(done), 64'(1));
        chk("zero_in_ready", 64'(bus.in_ready), 64'(0));
        chk("zero_busy", 64'(busy), 64'(0));
        tick();
        chk("zero_in_ready_later", 64'(bus.in_ready), 64'(0));
        chk("zero_word_count", 64'(word_count), 64'(0));
        chk("zero_writes", 64'(writes_seen - base), 64'(0));

        // Gapped valid pattern 1-0-0-1-1-0-1
        base = writes_seen;
        do_start(11'd1);
        exp_q.push_back('{addr: 12'h000, data: 32'hDDCC_BBAA});
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = p37[i];
            bus.in_data  = b37[idx];
            chk("gap_in_ready", 64'(bus.in_ready), 64'(1));
            tick();
            if (p37[i]) idx++;
        end
        bus.in_valid = 1'b0;
        chk("gap_wr_en_latency", 64'(bus.wr_en), 64'(1));
        chk("gap_write_in_ready", 64'(bus.in_ready), 64'(0));
        tick();
        chk("gap_done", 64'(done), 64'(1));
        chk("gap_word_count", 64'(word_count), 64'(1));
        chk("gap_writes", 64'(writes_seen - base), 64'(1));

        // start pulsed mid-word must be ignored
        base = writes_seen;
        do_start(11'd3);
        send_word($urandom, 0, 1'b0);
        w1 = $urandom;
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        start     = 1'b1;
        num_words = 11'd1;
        tick();
        start     = 1'b0;
        chk("ign_busy", 64'(busy), 64'(1));
        chk("ign_done", 64'(done), 64'(0));
        chk("ign_word_count", 64'(word_count), 64'(1));
        send_byte(w1[23:16]);
        exp_q.push_back('{addr: 12'h004, data: w1});
        send_byte(w1[31:24]);
        send_word($urandom, 2, 1'b0);
        wait_done(20, "ign_done_end");
        chk("ign_final_count", 64'(word_count), 64'(3));
        chk("ign_writes", 64'(writes_seen - base), 64'(3));

        // Reset mid-load, then a fresh one-word load
        do_start(11'd3);
        send_word($urandom, 0, 1'b0);
        send_byte(8'h55);
        send_byte(8'h66);
        base  = writes_seen;
        reset = 1'b1;
        #1 check_reset_outputs("midrst");
        tick();
        tick();
        chk("midrst_no_write", 64'(writes_seen - base), 64'(0));
        chk("midrst_sb_empty", 64'(exp_q.size()), 64'(0));
        reset = 1'b0;
        do_start(11'd1);
        chk("post_rst_busy", 64'(busy), 64'(1));
        exp_q.push_back('{addr: 12'h000, data: 32'h0403_0201});
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_done(20, "post_rst_done");
        chk("post_rst_count", 64'(word_count), 64'(1));
        chk("post_rst_writes", 64'(writes_seen - base), 64'(1));

        // Table of load lengths, including saturation
        foreach (vecs[v]) begin
            base = writes_seen;
            do_start(vecs[v].num);
            for (int w = 0; w < vecs[v].exp_words; w++) send_word($urandom, w, vecs[v].gaps);
            wait_done(20, $sformatf("vec%0d_done", v));
            chk($sformatf("vec%0d_count", v), 64'(word_count), 64'(vecs[v].exp_words));
            chk($sformatf("vec%0d_busy", v), 64'(busy), 64'(0));
            chk($sformatf("vec%0d_writes", v), 64'(writes_seen - base), 64'(vecs[v].exp_words));
            chk($sformatf("vec%0d_sb_empty", v), 64'(exp_q.size()), 64'(0));
            if (vecs[v].exp_words == 1024) chk($sformatf("vec%0d_last_addr", v), 64'(last_addr), 64'(12'hFFC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
